// File: rtl/tuple_sum_pkg.sv
// Shared types and default sizing for the triplet-sum search block.
package tuple_sum_pkg;

  localparam int DEF_W     = 8;
  localparam int DEF_DEPTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/tuple_idx_gen.sv
// Walks i<j<k over [0,n) in lexicographic order, one step per pulse.
module tuple_idx_gen #(
  parameter int IW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          step,
  input  logic [IW:0]   n,
  output logic [IW-1:0] i,
  output logic [IW-1:0] j,
  output logic [IW-1:0] k,
  output logic          last
);

  localparam logic [IW:0] ONE   = (IW+1)'(1);
  localparam logic [IW:0] TWO   = (IW+1)'(2);
  localparam logic [IW:0] THREE = (IW+1)'(3);

  logic [IW-1:0] i_q, j_q, k_q, i_d, j_d, k_d;
  logic [IW:0]   ie, je, ke;

  assign ie = {1'b0, i_q};
  assign je = {1'b0, j_q};
  assign ke = {1'b0, k_q};

  // i == n-3 forces j == n-2 and k == n-1, so it alone marks the final triplet
  assign last = (ie == n - THREE);

  always_comb begin
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    if (clear) begin
      i_d = '0;
      j_d = IW'(1);
      k_d = IW'(2);
    end else if (step) begin
      if (ke < n - ONE) begin
        k_d = IW'(ke + ONE);
      end else if (je < n - TWO) begin
        j_d = IW'(je + ONE);
        k_d = IW'(je + TWO);
      end else begin
        i_d = IW'(ie + ONE);
        j_d = IW'(ie + TWO);
        k_d = IW'(ie + THREE);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i_q <= '0;
      j_q <= IW'(1);
      k_q <= IW'(2);
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
    end
  end

  assign i = i_q;
  assign j = j_q;
  assign k = k_q;

endmodule

// File: rtl/tuple_sum_finder.sv
// Exhaustive search for element triplets whose signed sum equals a target,
// reporting each hit through a valid/ack handshake.
module tuple_sum_finder
  import tuple_sum_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_addr,
  input  logic [W-1:0]      wr_data,
  input  logic              start,
  input  logic [IW:0]       size,
  input  logic [W+1:0]      target,
  input  logic              ack,
  output logic              valid,
  output logic [3*W-1:0]    tuple,
  output logic [3*IW-1:0]   idx,
  output logic              busy,
  output logic              done,
  output logic [IW*3-1:0]   match_count
);

  localparam logic [IW:0] DEPTH_N = (IW+1)'(DEPTH);
  localparam logic [IW:0] MIN_N   = (IW+1)'(3);

  state_e            state_q, state_d;
  logic [W-1:0]      mem [DEPTH];
  logic [IW:0]       size_q, size_c;
  logic [W+1:0]      target_q;
  logic              valid_q, done_q;
  logic [3*W-1:0]    tuple_q;
  logic [3*IW-1:0]   idx_q;
  logic [IW*3-1:0]   cnt_q;

  logic [IW-1:0]     gi, gj, gk;
  logic              glast, clr, step;
  logic [W-1:0]      vi, vj, vk;
  logic [W+1:0]      sum;
  logic              start_ok, hit, busy_w, wr_ok;

  assign busy_w   = (state_q == ST_SCAN) || (state_q == ST_HOLD);
  assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign size_c   = (size > DEPTH_N) ? DEPTH_N : size;
  assign wr_ok    = ({1'b0, wr_addr} < DEPTH_N);

  always_ff @(posedge clk) begin
    if (wr_en && !busy_w && wr_ok) mem[wr_addr] <= wr_data;
  end

  tuple_idx_gen #(.IW(IW)) u_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clr),
    .step    (step),
    .n       (size_q),
    .i       (gi),
    .j       (gj),
    .k       (gk),
    .last    (glast)
  );

  assign vi = mem[gi];
  assign vj = mem[gj];
  assign vk = mem[gk];

  // W+2 bits hold any sum of three W-bit signed values exactly
  assign sum = {{2{vi[W-1]}}, vi} + {{2{vj[W-1]}}, vj} + {{2{vk[W-1]}}, vk};
  assign hit = (state_q == ST_SCAN) && (sum == target_q);

  assign clr  = start_ok;
  assign step = ((state_q == ST_SCAN) && !hit && !glast) ||
                ((state_q == ST_HOLD) && ack && !glast);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = (size_c < MIN_N) ? ST_DONE : ST_SCAN;
      ST_SCAN: begin
        if (hit)        state_d = ST_HOLD;
        else if (glast) state_d = ST_DONE;
      end
      ST_HOLD: if (ack) state_d = glast ? ST_DONE : ST_SCAN;
      default: state_d = ST_IDLE;
    endcase
  end

  // done trails entry into DONE by one cycle; a start clears it outright
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      size_q   <= '0;
      target_q <= '0;
      valid_q  <= 1'b0;
      tuple_q  <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        size_q   <= size_c;
        target_q <= target;
        cnt_q    <= '0;
        done_q   <= 1'b0;
      end else begin
        done_q <= (state_q == ST_DONE);
      end
      if (hit) begin
        valid_q <= 1'b1;
        tuple_q <= {vk, vj, vi};
        idx_q   <= {gk, gj, gi};
        cnt_q   <= cnt_q + (IW*3)'(1);
      end else if ((state_q == ST_HOLD) && ack) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign valid       = valid_q;
  assign tuple       = tuple_q;
  assign idx         = idx_q;
  assign busy        = busy_w;
  assign done        = done_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_tuple_sum_finder.sv
// Directed bench for tuple_sum_finder: match lists, timing, handshake, reset.
module tb_tuple_sum_finder;

  localparam int W     = 8;
  localparam int DEPTH = 16;
  localparam int IW    = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [IW-1:0]     wr_addr = '0;
  logic [W-1:0]      wr_data = '0;
  logic              start = 1'b0;
  logic [IW:0]       size = '0;
  logic [W+1:0]      target = '0;
  logic              ack = 1'b0;
  logic              valid, busy, done;
  logic [3*W-1:0]    tuple;
  logic [3*IW-1:0]   idx;
  logic [IW*3-1:0]   match_count;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  tuple_sum_finder #(.W(W), .DEPTH(DEPTH), .IW(IW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .start       (start),
    .size        (size),
    .target      (target),
    .ack         (ack),
    .valid       (valid),
    .tuple       (tuple),
    .idx         (idx),
    .busy        (busy),
    .done        (done),
    .match_count (match_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int v);
    wr_en = 1'b1; wr_addr = IW'(a); wr_data = W'(v);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic load_a();
    int va[7] = '{-4, -1, -1, 0, 1, 2, 3};
    foreach (va[n]) wr(n, va[n]);
  endtask

  task automatic go(input int n, input int t);
    start = 1'b1; size = (IW+1)'(n); target = (W+2)'(t);
    tick();
    start = 1'b0;
  endtask

  task automatic zeros(input string tag);
    chk({tag, " valid"}, valid, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " tuple/idx/cnt"}, {tuple, idx, match_count}, 0);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!valid && n < 300) begin tick(); n++; end
  endtask

  task automatic expect_match(input string tag, input logic [11:0] e_idx,
                              input logic [23:0] e_tup, input int dly);
    bit stable = 1'b1;
    wait_valid();
    chk({tag, " valid"}, valid, 1);
    chk({tag, " idx"}, idx, e_idx);
    chk({tag, " tuple"}, tuple, e_tup);
    repeat (dly) begin
      tick();
      if (!valid || idx !== e_idx || tuple !== e_tup) stable = 1'b0;
    end
    chk({tag, " stable"}, stable, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk({tag, " drop"}, valid, 0);
  endtask

  task automatic finish_run(input string tag, input int e_cnt);
    int n = 0;
    bit seen = 1'b0;
    while (!done && n < 300) begin
      tick(); n++;
      if (valid) seen = 1'b1;
    end
    chk({tag, " done"}, done, 1);
    chk({tag, " extra valid"}, seen, 0);
    chk({tag, " count"}, match_count, e_cnt);
    chk({tag, " busy"}, busy, 0);
  endtask

  task automatic list_a(input string tag, input int dly);
    expect_match({tag, " m0"}, 12'h640, 24'h0301FC, dly);
    expect_match({tag, " m1"}, 12'h521, 24'h02FFFF, dly);
    expect_match({tag, " m2"}, 12'h431, 24'h0100FF, dly);
    expect_match({tag, " m3"}, 12'h432, 24'h0100FF, dly);
    finish_run(tag, 4);
  endtask

  initial begin
    int cyc;
    bit seen;

    tick(); tick();
    zeros("reset");
    reset_n = 1'b1;
    tick();
    zeros("idle");

    // target 0, ack one cycle after each valid
    load_a();
    go(7, 0);
    chk("t0 busy", busy, 1);
    list_a("t0", 1);
    tick(); tick();
    chk("done hold", done, 1);

    // no match: timing from start edge; writes and starts while busy are dropped
    go(7, 100);
    chk("t100 busy", busy, 1);
    wr_en = 1'b1; wr_addr = '0; wr_data = 8'd50; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    cyc = 1; seen = 1'b0;
    while (!done && cyc < 100) begin
      tick(); cyc++;
      if (valid) seen = 1'b1;
    end
    chk("t100 cycles", cyc, 36);
    chk("t100 valid", seen, 0);
    chk("t100 count", match_count, 0);

    // long ack delay, store must still hold the original data
    go(7, 0);
    list_a("slow", 10);

    // short size goes straight to done
    go(2, 0);
    cyc = 0; seen = 1'b0;
    while (!done && cyc < 20) begin
      tick(); cyc++;
      if (valid) seen = 1'b1;
    end
    chk("sz2 cycles", cyc, 1);
    chk("sz2 valid", seen, 0);
    chk("sz2 count", match_count, 0);

    // reset while a result is held
    go(7, 0);
    wait_valid();
    chk("hold valid", valid, 1);
    reset_n = 1'b0;
    #1;
    zeros("async rst");
    tick();
    reset_n = 1'b1;
    tick();
    load_a();
    go(7, 0);
    list_a("post rst", 1);

    // saturating extremes
    wr(0, 127); wr(1, 127); wr(2, 127);
    wr(3, -128); wr(4, -128); wr(5, -128);
    go(6, 381);
    expect_match("max", 12'h210, 24'h7F7F7F, 1);
    finish_run("max", 1);
    go(6, -384);
    expect_match("min", 12'h543, 24'h808080, 1);
    finish_run("min", 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
